// File: rtl/apb_master.sv
// Single-channel APB master: bridge requests become SETUP/ACCESS transfers to
// one of two slaves (address bit 8 picks the slave), with PREADY wait states.
module apb_master (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic [8:0] apb_write_paddr,
  input  logic [8:0] apb_read_paddr,
  input  logic [7:0] apb_write_data,
  input  logic       READ_WRITE,
  input  logic       transfer,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic [8:0] PADDR,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  output logic [7:0] apb_read_data_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t     r_state;
  logic [8:0] w_next_addr;
  logic       w_done;
  logic       w_start;

  assign w_next_addr = READ_WRITE ? apb_read_paddr : apb_write_paddr;
  assign w_done      = (r_state == ST_ACCESS) && PREADY;
  // A new transfer is launched from IDLE or straight out of a completing ACCESS.
  assign w_start     = transfer && ((r_state == ST_IDLE) || w_done);

  // PRESETn is active-high despite its name.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      r_state           <= ST_IDLE;
      PSEL1             <= 1'b0;
      PSEL2             <= 1'b0;
      PENABLE           <= 1'b0;
      PADDR             <= '0;
      PWRITE            <= 1'b0;
      PWDATA            <= '0;
      apb_read_data_out <= '0;
    end else begin
      // Read capture uses the in-flight direction, before any reload below.
      if (w_done && !PWRITE) begin
        apb_read_data_out <= PRDATA;
      end

      if (w_start) begin
        r_state <= ST_SETUP;
        PADDR   <= w_next_addr;
        PWRITE  <= ~READ_WRITE;
        PWDATA  <= READ_WRITE ? '0 : apb_write_data;
        PSEL1   <= ~w_next_addr[8];
        PSEL2   <= w_next_addr[8];
        PENABLE <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            PSEL1   <= 1'b0;
            PSEL2   <= 1'b0;
            PENABLE <= 1'b0;
          end
          ST_SETUP: begin
            r_state <= ST_ACCESS;
            PENABLE <= 1'b1;
          end
          ST_ACCESS: begin
            if (PREADY) begin
              r_state <= ST_IDLE;
              PSEL1   <= 1'b0;
              PSEL2   <= 1'b0;
              PENABLE <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            PSEL1   <= 1'b0;
            PSEL2   <= 1'b0;
            PENABLE <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: writes/reads to both slaves, wait states,
// back-to-back transfers, asynchronous reset mid-ACCESS and idle hold.
module tb_apb_master;

  logic       PCLK;
  logic       PRESETn;
  logic [8:0] apb_write_paddr;
  logic [8:0] apb_read_paddr;
  logic [7:0] apb_write_data;
  logic       READ_WRITE;
  logic       transfer;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSEL1;
  logic       PSEL2;
  logic       PENABLE;
  logic [8:0] PADDR;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] apb_read_data_out;

  int unsigned errors;
  int unsigned checks;

  apb_master u_dut (
    .PCLK             (PCLK),
    .PRESETn          (PRESETn),
    .apb_write_paddr  (apb_write_paddr),
    .apb_read_paddr   (apb_read_paddr),
    .apb_write_data   (apb_write_data),
    .READ_WRITE       (READ_WRITE),
    .transfer         (transfer),
    .PRDATA           (PRDATA),
    .PREADY           (PREADY),
    .PSEL1            (PSEL1),
    .PSEL2            (PSEL2),
    .PENABLE          (PENABLE),
    .PADDR            (PADDR),
    .PWRITE           (PWRITE),
    .PWDATA           (PWDATA),
    .apb_read_data_out(apb_read_data_out)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Control vector order: {PSEL1, PSEL2, PENABLE, PWRITE}
  task automatic test_reset();
    PRESETn = 1'b1;
    transfer = 1'b0; READ_WRITE = 1'b0; PREADY = 1'b0; PRDATA = 8'h00;
    apb_write_paddr = 9'h1FF; apb_read_paddr = 9'h1FF; apb_write_data = 8'hFF;
    tick(); tick();
    checks++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, apb_read_data_out} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, apb_read_data_out});
    end
    @(negedge PCLK);
    PRESETn = 1'b0;
    tick();
    checks++;
    if ({PSEL1, PSEL2, PENABLE} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_idle got=%b exp=000", {PSEL1, PSEL2, PENABLE});
    end
  endtask

  task automatic test_write_slave1();
    transfer = 1'b1; READ_WRITE = 1'b0; apb_write_paddr = 9'h002;
    apb_write_data = 8'h33; PREADY = 1'b1;
    tick();
    checks++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b1001 || PADDR !== 9'h002 || PWDATA !== 8'h33) begin
      errors++;
      $display("FAIL wr1_setup got ctl=%b addr=%h data=%h exp ctl=1001 addr=002 data=33",
               {PSEL1, PSEL2, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    transfer = 1'b0;
    tick();
    checks++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b1011 || PADDR !== 9'h002 || PWDATA !== 8'h33) begin
      errors++;
      $display("FAIL wr1_access got ctl=%b addr=%h data=%h exp ctl=1011 addr=002 data=33",
               {PSEL1, PSEL2, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    tick();
    checks++;
    if ({PSEL1, PSEL2, PENABLE} !== 3'b000 || apb_read_data_out !== 8'h00) begin
      errors++;
      $display("FAIL wr1_idle got ctl=%b rdata=%h exp ctl=000 rdata=00",
               {PSEL1, PSEL2, PENABLE}, apb_read_data_out);
    end
  endtask

  task automatic test_read_slave1();
    transfer = 1'b1; READ_WRITE = 1'b1; apb_read_paddr = 9'h002;
    apb_write_paddr = 9'h0AA; apb_write_data = 8'hC3; PRDATA = 8'h33; PREADY = 1'b1;
    tick();
    checks++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b1000 || PADDR !== 9'h002 || PWDATA !== 8'h00) begin
      errors++;
      $display("FAIL rd1_setup got ctl=%b addr=%h data=%h exp ctl=1000 addr=002 data=00",
               {PSEL1, PSEL2, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    transfer = 1'b0;
    tick();
    checks++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b1010 || apb_read_data_out !== 8'h00) begin
      errors++;
      $display("FAIL rd1_access got ctl=%b rdata=%h exp ctl=1010 rdata=00",
               {PSEL1, PSEL2, PENABLE, PWRITE}, apb_read_data_out);
    end
    tick();
    PRDATA = 8'h99;
    checks++;
    if ({PSEL1, PSEL2, PENABLE} !== 3'b000 || apb_read_data_out !== 8'h33) begin
      errors++;
      $display("FAIL rd1_capture got ctl=%b rdata=%h exp ctl=000 rdata=33",
               {PSEL1, PSEL2, PENABLE}, apb_read_data_out);
    end
  endtask

  task automatic test_write_slave2_wait();
    transfer = 1'b1; READ_WRITE = 1'b0; apb_write_paddr = 9'h102;
    apb_write_data = 8'h0F; PREADY = 1'b1;
    tick();
    checks++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b0101 || PADDR !== 9'h102) begin
      errors++;
      $display("FAIL wr2_setup got ctl=%b addr=%h exp ctl=0101 addr=102",
               {PSEL1, PSEL2, PENABLE, PWRITE}, PADDR);
    end
    // PREADY high during SETUP must not shorten the transfer.
    transfer = 1'b0; apb_write_paddr = 9'h055; apb_write_data = 8'hEE;
    tick();
    PREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b0111 || PADDR !== 9'h102 || PWDATA !== 8'h0F) begin
        errors++;
        $display("FAIL wr2_access_%0d got ctl=%b addr=%h data=%h exp ctl=0111 addr=102 data=0F",
                 i, {PSEL1, PSEL2, PENABLE, PWRITE}, PADDR, PWDATA);
      end
      if (i == 2) PREADY = 1'b1;
      tick();
    end
    checks++;
    if ({PSEL1, PSEL2, PENABLE} !== 3'b000 || apb_read_data_out !== 8'h33) begin
      errors++;
      $display("FAIL wr2_done got ctl=%b rdata=%h exp ctl=000 rdata=33",
               {PSEL1, PSEL2, PENABLE}, apb_read_data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] addrs [3];
    logic [7:0] datas [3];
    addrs[0] = 9'h010; addrs[1] = 9'h011; addrs[2] = 9'h012;
    datas[0] = 8'hA1;  datas[1] = 8'hA2;  datas[2] = 8'hA3;
    transfer = 1'b1; READ_WRITE = 1'b0; PREADY = 1'b1;
    apb_write_paddr = addrs[0]; apb_write_data = datas[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b1001 || PADDR !== addrs[i] || PWDATA !== datas[i]) begin
        errors++;
        $display("FAIL b2b_setup_%0d got ctl=%b addr=%h data=%h exp ctl=1001 addr=%h data=%h",
                 i, {PSEL1, PSEL2, PENABLE, PWRITE}, PADDR, PWDATA, addrs[i], datas[i]);
      end
      if (i < 2) begin
        apb_write_paddr = addrs[i+1]; apb_write_data = datas[i+1];
      end
      tick();
      checks++;
      if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b1011 || PADDR !== addrs[i]) begin
        errors++;
        $display("FAIL b2b_access_%0d got ctl=%b addr=%h exp ctl=1011 addr=%h",
                 i, {PSEL1, PSEL2, PENABLE, PWRITE}, PADDR, addrs[i]);
      end
      if (i == 2) transfer = 1'b0;
    end
    tick();
    checks++;
    if ({PSEL1, PSEL2, PENABLE} !== 3'b000 || PADDR !== 9'h012) begin
      errors++;
      $display("FAIL b2b_stop got ctl=%b addr=%h exp ctl=000 addr=012",
               {PSEL1, PSEL2, PENABLE}, PADDR);
    end
  endtask

  task automatic test_reset_mid_access();
    transfer = 1'b1; READ_WRITE = 1'b1; apb_read_paddr = 9'h1AB;
    PRDATA = 8'h5A; PREADY = 1'b0;
    tick();
    transfer = 1'b0;
    tick();
    checks++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b0110 || PADDR !== 9'h1AB) begin
      errors++;
      $display("FAIL rst_pre_access got ctl=%b addr=%h exp ctl=0110 addr=1AB",
               {PSEL1, PSEL2, PENABLE, PWRITE}, PADDR);
    end
    #2;
    PRESETn = 1'b1;
    #1;
    checks++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, apb_read_data_out} !== 29'd0) begin
      errors++;
      $display("FAIL rst_async got=%h exp=0",
               {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, apb_read_data_out});
    end
    PREADY = 1'b1;
    tick();
    checks++;
    if (apb_read_data_out !== 8'h00 || PENABLE !== 1'b0) begin
      errors++;
      $display("FAIL rst_held got rdata=%h en=%b exp rdata=00 en=0", apb_read_data_out, PENABLE);
    end
    @(negedge PCLK);
    PRESETn = 1'b0;
    tick(); tick();
    checks++;
    if ({PSEL1, PSEL2, PENABLE} !== 3'b000 || apb_read_data_out !== 8'h00) begin
      errors++;
      $display("FAIL rst_after_release got ctl=%b rdata=%h exp ctl=000 rdata=00",
               {PSEL1, PSEL2, PENABLE}, apb_read_data_out);
    end
  endtask

  task automatic test_idle_hold();
    transfer = 1'b0;
    for (int i = 0; i < 10; i++) begin
      apb_write_paddr = 9'(i * 37 + 5);
      apb_read_paddr  = 9'(i * 53 + 300);
      apb_write_data  = 8'(i * 29 + 1);
      READ_WRITE      = i[0];
      PREADY          = i[1];
      tick();
      checks++;
      if ({PSEL1, PSEL2, PENABLE} !== 3'b000 || PADDR !== 9'h000) begin
        errors++;
        $display("FAIL idle_hold_%0d got ctl=%b addr=%h exp ctl=000 addr=000",
                 i, {PSEL1, PSEL2, PENABLE}, PADDR);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_write_slave1();
    test_read_slave1();
    test_write_slave2_wait();
    test_back_to_back();
    test_reset_mid_access();
    test_idle_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
